// File: rtl/serial_port_endpoint_pkg.sv
// Shared widths and defaults for the serial port endpoint.
// Byte width, FIFO depth default and transmit counter width.
package serial_port_endpoint_pkg;
    localparam int BYTE_W        = 8;
    localparam int DEFAULT_DEPTH = 8;
    localparam int COUNT_W       = 16;

    typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/serial_port_endpoint_byte_fifo.sv
// First-word-fall-through byte FIFO; head shows the oldest entry, 8'h00 when empty.
// Latency: a byte pushed at edge N is at the head in the following cycle.
// Backpressure: full/empty come from registered pointers only; push when full and pop when empty are ignored.
module byte_fifo
    import serial_port_endpoint_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  push,
    input  byte_t push_dat,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output byte_t head
);
    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty when the low bits match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    byte_t       mem [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: stale entries are never visible past the empty mask.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/serial_port_endpoint.sv
// Bridges a host byte stream and a processor serial port through one FIFO per direction.
// Latency: one cycle through either FIFO.
// Backpressure: readies are registered not-full; dropped processor writes and empty reads set sticky error flags.
module serial_port_endpoint
    import serial_port_endpoint_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clock,
    input  logic               reset,
    output byte_t              proc_rdata,
    output logic               proc_rvalid,
    input  logic               proc_rden,
    output logic               proc_wready,
    input  byte_t              proc_wdata,
    input  logic               proc_wren,
    input  byte_t              host_in_data,
    input  logic               host_in_valid,
    output logic               host_in_ready,
    output byte_t              host_out_data,
    output logic               host_out_valid,
    input  logic               host_out_ready,
    output logic               err_overflow,
    output logic               err_underflow,
    output logic [COUNT_W-1:0] tx_count
);
    logic rx_full;
    logic rx_empty;
    logic tx_full;
    logic tx_empty;

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (host_in_valid),
        .push_dat (host_in_data),
        .pop      (proc_rden),
        .full     (rx_full),
        .empty    (rx_empty),
        .head     (proc_rdata)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (proc_wren),
        .push_dat (proc_wdata),
        .pop      (host_out_ready),
        .full     (tx_full),
        .empty    (tx_empty),
        .head     (host_out_data)
    );

    assign host_in_ready  = !rx_full;
    assign proc_rvalid    = !rx_empty;
    assign proc_wready    = !tx_full;
    assign host_out_valid = !tx_empty;

    always_ff @(posedge clock) begin
        if (!reset) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            tx_count      <= '0;
        end else begin
            if (proc_wren && tx_full)   err_overflow  <= 1'b1;
            if (proc_rden && rx_empty)  err_underflow <= 1'b1;
            if (proc_wren && !tx_full)  tx_count      <= tx_count + COUNT_W'(1);
        end
    end
endmodule

// File: tb/tb_serial_port_endpoint.sv
// Scoreboard bench: occupancy/queue reference model updated per edge, monitor compares at the falling edge.
module tb_serial_port_endpoint;
    import serial_port_endpoint_pkg::*;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  proc_rdata;
    logic        proc_rvalid;
    logic        proc_rden = 1'b0;
    logic        proc_wready;
    logic [7:0]  proc_wdata = 8'h00;
    logic        proc_wren = 1'b0;
    logic [7:0]  host_in_data = 8'h00;
    logic        host_in_valid = 1'b0;
    logic        host_in_ready;
    logic [7:0]  host_out_data;
    logic        host_out_valid;
    logic        host_out_ready = 1'b0;
    logic        err_overflow;
    logic        err_underflow;
    logic [15:0] tx_count;

    always #5 clock = ~clock;

    serial_port_endpoint #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .proc_rdata     (proc_rdata),
        .proc_rvalid    (proc_rvalid),
        .proc_rden      (proc_rden),
        .proc_wready    (proc_wready),
        .proc_wdata     (proc_wdata),
        .proc_wren      (proc_wren),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow),
        .tx_count       (tx_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy counts plus queues of accepted bytes awaiting delivery.
    int         rx_occ = 0;
    int         tx_occ = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    bit         ov_m = 1'b0;
    bit         un_m = 1'b0;
    logic [15:0] cnt_m = 16'h0;
    bit         armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) step();
        reset = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            if (!reset) begin
                rx_occ = 0;
                tx_occ = 0;
                rx_exp.delete();
                tx_exp.delete();
                ov_m   = 1'b0;
                un_m   = 1'b0;
                cnt_m  = 16'h0;
                armed  = 1'b1;
            end else if (armed) begin
                bit rp, rq, tp, tq;
                rp = host_in_valid && (rx_occ < DEPTH);
                rq = proc_rden && (rx_occ > 0);
                tp = proc_wren && (tx_occ < DEPTH);
                tq = host_out_ready && (tx_occ > 0);
                if (proc_rden && rx_occ == 0) un_m = 1'b1;
                if (proc_wren && !tp) ov_m = 1'b1;
                if (rp) rx_exp.push_back(host_in_data);
                if (tp) begin
                    tx_exp.push_back(proc_wdata);
                    cnt_m = cnt_m + 16'h1;
                end
                rx_occ = rx_occ + int'(rp) - int'(rq);
                tx_occ = tx_occ + int'(tp) - int'(tq);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (armed) begin
                check("proc_rvalid", 32'(proc_rvalid), 32'(rx_occ > 0));
                check("host_in_ready", 32'(host_in_ready), 32'(rx_occ < DEPTH));
                check("host_out_valid", 32'(host_out_valid), 32'(tx_occ > 0));
                check("proc_wready", 32'(proc_wready), 32'(tx_occ < DEPTH));
                check("err_overflow", 32'(err_overflow), 32'(ov_m));
                check("err_underflow", 32'(err_underflow), 32'(un_m));
                check("tx_count", 32'(tx_count), 32'(cnt_m));
                if (rx_occ == 0) check("proc_rdata_empty", 32'(proc_rdata), 32'h0);
                if (tx_occ == 0) check("host_out_data_empty", 32'(host_out_data), 32'h0);
                if (reset && proc_rden && proc_rvalid && rx_exp.size() > 0)
                    check("rx_byte", 32'(proc_rdata), 32'(rx_exp.pop_front()));
                if (reset && host_out_ready && host_out_valid && tx_exp.size() > 0)
                    check("tx_byte", 32'(host_out_data), 32'(tx_exp.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] got[$];

        do_reset(2);
        check("reset_rvalid", 32'(proc_rvalid), 32'h0);
        check("reset_wready", 32'(proc_wready), 32'h1);

        // Two host bytes back-to-back, processor popping one per cycle.
        host_in_valid = 1'b1; host_in_data = 8'h48;
        step();
        check("hello_first", 32'(proc_rdata), 32'h48);
        host_in_data = 8'h69; proc_rden = 1'b1;
        step();
        check("hello_second", 32'(proc_rdata), 32'h69);
        host_in_valid = 1'b0;
        step();
        proc_rden = 1'b0;
        check("hello_drained", 32'(proc_rvalid), 32'h0);

        // Nine processor writes into an 8-deep TX FIFO with the host stalled.
        host_out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            proc_wren = 1'b1; proc_wdata = 8'(i);
            step();
        end
        proc_wren = 1'b0;
        check("fill_wready", 32'(proc_wready), 32'h0);
        check("fill_overflow", 32'(err_overflow), 32'h1);
        check("fill_count", 32'(tx_count), 32'h8);

        host_out_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 20 && host_out_valid; i++) begin
            got.push_back(host_out_data);
            step();
        end
        host_out_ready = 1'b0;
        check("drain_len", 32'(got.size()), 32'h8);
        for (int i = 0; i < got.size(); i++) check("drain_order", 32'(got[i]), 32'(i));
        check("drain_valid", 32'(host_out_valid), 32'h0);

        // Read with RX empty, then a host byte must still get through.
        proc_rden = 1'b1;
        step();
        proc_rden = 1'b0;
        check("under_flag", 32'(err_underflow), 32'h1);
        host_in_valid = 1'b1; host_in_data = 8'h5A;
        step();
        host_in_valid = 1'b0;
        check("under_next", 32'(proc_rdata), 32'h5A);
        proc_rden = 1'b1;
        step();
        proc_rden = 1'b0;
        check("under_drained", 32'(proc_rvalid), 32'h0);

        // Write against full versus one-below-full while the host pops.
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            proc_wren = 1'b1; proc_wdata = 8'h10 + 8'(i);
            step();
        end
        proc_wren = 1'b1; proc_wdata = 8'hAA; host_out_ready = 1'b1;
        step();
        proc_wren = 1'b0; host_out_ready = 1'b0;
        check("full_drop_flag", 32'(err_overflow), 32'h1);
        check("full_drop_count", 32'(tx_count), 32'h8);
        proc_wren = 1'b1; proc_wdata = 8'hAA; host_out_ready = 1'b1;
        step();
        proc_wren = 1'b0; host_out_ready = 1'b0;
        check("seven_accept_count", 32'(tx_count), 32'h9);
        host_out_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 20 && host_out_valid; i++) begin
            got.push_back(host_out_data);
            step();
        end
        host_out_ready = 1'b0;
        check("seven_len", 32'(got.size()), 32'h7);
        if (got.size() == 7) begin
            check("seven_head", 32'(got[0]), 32'h12);
            check("seven_tail", 32'(got[6]), 32'hAA);
        end

        // Reset with three bytes buffered each way and strobes active.
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            host_in_valid = 1'b1; host_in_data = 8'hC0 + 8'(i);
            proc_wren = 1'b1; proc_wdata = 8'hD0 + 8'(i);
            step();
        end
        proc_rden = 1'b1; host_out_ready = 1'b1;
        reset = 1'b0;
        step();
        step();
        check("rst_rvalid", 32'(proc_rvalid), 32'h0);
        check("rst_ovalid", 32'(host_out_valid), 32'h0);
        check("rst_iready", 32'(host_in_ready), 32'h1);
        check("rst_wready", 32'(proc_wready), 32'h1);
        check("rst_flags", 32'({err_overflow, err_underflow}), 32'h0);
        check("rst_count", 32'(tx_count), 32'h0);
        reset = 1'b1;
        host_in_valid = 1'b0; proc_wren = 1'b0; proc_rden = 1'b0; host_out_ready = 1'b0;
        step();

        // Randomized traffic with biased rates to reach both full and empty.
        for (int blk = 0; blk < 6; blk++) begin
            int p_in, p_out;
            p_in  = 20 + 15 * blk;
            p_out = 95 - 15 * blk;
            for (int c = 0; c < 500; c++) begin
                host_in_valid  = ($urandom_range(0, 99) < p_in);
                host_in_data   = 8'($urandom);
                proc_wren      = ($urandom_range(0, 99) < p_in);
                proc_wdata     = 8'($urandom);
                proc_rden      = ($urandom_range(0, 99) < p_out);
                host_out_ready = ($urandom_range(0, 99) < p_out);
                reset          = ($urandom_range(0, 399) != 0);
                step();
            end
        end
        reset = 1'b1;
        host_in_valid = 1'b0; proc_wren = 1'b0; proc_rden = 1'b0; host_out_ready = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_port_endpoint.md
SERIAL_PORT_ENDPOINT -- requirements
Module: serial_port_endpoint

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entries per direction FIFO; power of two, 2..64.
REQ-002 SHALL have input clock, 1 bit: all state updates on rising edge.
REQ-003 SHALL have input reset, 1 bit: synchronous, active-low; clock is clock.
REQ-004 SHALL have output proc_rdata, 8 bits: byte to processor; drives processor serial_in.
REQ-005 SHALL have output proc_rvalid, 1 bit: byte available; drives serial_valid_in.
REQ-006 SHALL have input proc_rden, 1 bit: processor consumes proc_rdata; from serial_rden_out.
REQ-007 SHALL have output proc_wready, 1 bit: endpoint accepts a processor byte; drives serial_ready_in.
REQ-008 SHALL have input proc_wdata, 8 bits: byte from processor; from serial_out.
REQ-009 SHALL have input proc_wren, 1 bit: processor write strobe; from serial_wren_out.
REQ-010 SHALL have input host_in_data, 8 bits: host byte bound for the processor.
REQ-011 SHALL have input host_in_valid, 1 bit: host_in_data valid.
REQ-012 SHALL have output host_in_ready, 1 bit: RX FIFO not full.
REQ-013 SHALL have output host_out_data, 8 bits: processor byte bound for the host.
REQ-014 SHALL have output host_out_valid, 1 bit: TX FIFO not empty.
REQ-015 SHALL have input host_out_ready, 1 bit: host accepts host_out_data.
REQ-016 SHALL have output err_overflow, 1 bit: sticky, proc_wren seen while proc_wready low.
REQ-017 SHALL have output err_underflow, 1 bit: sticky, proc_rden seen while proc_rvalid low.
REQ-018 SHALL have output tx_count, 16 bits: bytes accepted from processor, wraps 0xFFFF->0.

Function
REQ-019 RX path (host->processor) SHALL be a first-word-fall-through FIFO: proc_rdata = head entry, proc_rvalid = not empty.
REQ-020 TX path (processor->host) SHALL be a first-word-fall-through FIFO: host_out_data = head, host_out_valid = not empty.
REQ-021 Push SHALL occur on an edge where valid/strobe and ready are both high; pop on an edge where consumer strobe/ready and valid are both high.
REQ-022 Latency SHALL be 1 cycle: byte pushed at edge N is visible on the output side in the cycle after edge N.
REQ-023 Ready signals SHALL be registered-state derived (not full), independent of same-cycle pop; a push when full is dropped even if a pop occurs that edge.
REQ-024 Simultaneous push and pop on a non-empty, non-full FIFO SHALL keep occupancy unchanged and preserve order.
REQ-025 Pop when empty SHALL be ignored (no pointer move); push into empty in the same cycle SHALL still succeed.
REQ-026 proc_wren with proc_wready low SHALL drop the byte and set err_overflow; proc_rden with proc_rvalid low SHALL set err_underflow.
REQ-027 host_in_valid while host_in_ready low SHALL leave the byte pending (host holds it); no error flag.
REQ-028 Pointers SHALL be log2(DEPTH)+1 bits; full when MSBs differ and low bits equal, empty when equal; wrap naturally.
REQ-029 tx_count SHALL increment by 1 on each accepted processor write.
REQ-030 Byte order in each direction SHALL be strictly FIFO; no byte duplicated or reordered.

Reset
REQ-031 On reset low at an edge: both FIFOs empty, proc_rvalid=0, host_out_valid=0, proc_wready=1, host_in_ready=1, err flags=0, tx_count=0.
REQ-032 Reset mid-transfer SHALL discard all buffered bytes; strobes during reset SHALL have no effect.
REQ-033 proc_rdata and host_out_data SHALL be 8'h00 while the corresponding FIFO is empty.

Structure
REQ-034 Shared package SHALL hold BYTE_W=8, DEFAULT_DEPTH=8, COUNT_W=16.
REQ-035 A single sub-module byte_fifo (parameter DEPTH; push/pop/full/empty/head) SHALL be instantiated twice.
REQ-036 No combinational path SHALL exist from proc_rden or proc_wren to any ready/valid output.

Verification
REQ-037 Host pushes 0x48,0x69 back-to-back; processor pops one per cycle -> proc_rdata 0x48 then 0x69, proc_rvalid low after second pop.
REQ-038 Processor writes 9 bytes 0x00..0x08, host_out_ready=0, DEPTH=8 -> proc_wready low after 8th, 9th dropped, err_overflow=1, tx_count=8.
REQ-039 Then host_out_ready=1 -> host receives 0x00..0x07 in order, host_out_valid low after 8 pops.
REQ-040 proc_rden with RX empty -> err_underflow=1, pointers unchanged, next host byte 0x5A still delivered.
REQ-041 Full TX FIFO, simultaneous proc_wren(0xAA) and host pop -> 0xAA dropped, err_overflow=1; with 7 entries same stimulus -> 0xAA accepted, occupancy stays 7.
REQ-042 Reset low with 3 bytes buffered each way -> next cycle both valids 0, readies 1, flags 0, tx_count 0.
